// File: rtl/lcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcp_pkg
// Description : Shared types and key codes for the logic-chain puzzle stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lcp_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INV  = 3'd1,
        ST_OP   = 3'd2,
        ST_ROT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [3:0] c_key_submit = 4'd0;
    localparam logic [3:0] c_key_star   = 4'd10;
    localparam logic [3:0] c_key_hash   = 4'd11;

    // Power-on operand pattern, truncated by the caller to the operand width.
    function automatic logic [7:0] init_num(input int k);
        return 8'h12 + 8'h22 * 8'(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcp_calc.sv
`default_nettype none
// ============================================================================
// Module      : lcp_calc
// Description : Combinational left-to-right operator chain, no carries.
// Revision    : 1.0 - initial release
// ============================================================================
module lcp_calc
    import lcp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_STAGES = 8
) (
    input  logic [N_STAGES:0][WIDTH-1:0] i_nums,
    input  logic [N_STAGES-1:0][1:0]     i_ops,
    input  logic [N_STAGES-1:0]          i_dip_sw,
    output logic [WIDTH-1:0]             o_result
);

    logic [WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = i_nums[0];
        for (int i = 0; i < N_STAGES; i++) begin
            if (i_dip_sw[i]) begin
                case (op_e'(i_ops[i]))
                    OP_AND:  w_acc = w_acc & i_nums[i+1];
                    OP_OR:   w_acc = w_acc | i_nums[i+1];
                    OP_XOR:  w_acc = w_acc ^ i_nums[i+1];
                    default: w_acc = ~(w_acc ^ i_nums[i+1]);
                endcase
            end
        end
    end

    assign o_result = w_acc;

endmodule
`default_nettype wire

// File: rtl/logic_chain_puzzle.sv
`default_nettype none
// ============================================================================
// Module      : logic_chain_puzzle
// Description : Keypad-driven logic-chain puzzle; optional one-level undo
//               on '#' when LCP_UNDO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_chain_puzzle
    import lcp_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               N_STAGES  = 8,
    parameter int               MAX_MOVES = 12,
    parameter logic [WIDTH-1:0] TARGET    = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [N_STAGES-1:0] dip_sw,
    input  logic                key_valid,
    input  logic [3:0]          key_value,
    output logic [31:0]         seg_data,
    output logic [7:0]          led_out,
    output logic                clear,
    output logic                fail,
    output logic                correct
);

    logic [N_STAGES:0][WIDTH-1:0] r_nums, w_nums, w_init;
    logic [N_STAGES-1:0][1:0]     r_ops, w_ops;
    state_e                       r_state, w_state;
    logic [3:0]                   r_count, w_count;
    logic                         r_clear, r_fail, r_correct;
    logic                         w_clear, w_fail, w_correct;
    logic [7:0]                   r_led, w_led;
    logic [WIDTH-1:0]             w_result;
    logic [3:0]                   w_idx;
    logic                         w_is_sel, w_edit_mode, w_in_range;
`ifdef LCP_UNDO_EN
    logic                         r_snap_valid, w_snap_valid;
    logic                         r_snap_op, w_snap_op;
    logic [3:0]                   r_snap_idx, w_snap_idx;
    logic [7:0]                   r_snap_val, w_snap_val;
`endif

    for (genvar gk = 0; gk <= N_STAGES; gk++) begin : g_init
        localparam logic [7:0] c_init = init_num(gk);
        assign w_init[gk] = c_init[WIDTH-1:0];
    end

    lcp_calc #(.WIDTH(WIDTH), .N_STAGES(N_STAGES)) u_calc (
        .i_nums   (r_nums),
        .i_ops    (r_ops),
        .i_dip_sw (dip_sw),
        .o_result (w_result)
    );

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
        return (x << 1) | (x >> (WIDTH - 1));
    endfunction

    assign w_idx       = key_value - 4'd1;
    assign w_is_sel    = (key_value >= 4'd1) && (key_value <= 4'd9);
    assign w_edit_mode = (r_state == ST_INV) || (r_state == ST_OP) || (r_state == ST_ROT);
    assign w_in_range  = (r_state == ST_OP) ? (key_value <= 4'(N_STAGES))
                                            : (key_value <= 4'(N_STAGES + 1));

    always_comb begin
        w_nums    = r_nums;
        w_ops     = r_ops;
        w_state   = r_state;
        w_count   = r_count;
        w_clear   = 1'b0;
        w_fail    = 1'b0;
        w_correct = 1'b0;
`ifdef LCP_UNDO_EN
        w_snap_valid = r_snap_valid;
        w_snap_op    = r_snap_op;
        w_snap_idx   = r_snap_idx;
        w_snap_val   = r_snap_val;
`endif
        if (enable && key_valid && (r_state != ST_DONE)) begin
            if (key_value == c_key_star) begin
                case (r_state)
                    ST_IDLE: w_state = ST_INV;
                    ST_INV:  w_state = ST_OP;
                    ST_OP:   w_state = ST_ROT;
                    default: w_state = ST_IDLE;
                endcase
            end else if (key_value == c_key_submit) begin
                if (w_result == TARGET) begin
                    w_clear   = 1'b1;
                    w_correct = 1'b1;
                    w_state   = ST_DONE;
                end else begin
                    w_fail  = 1'b1;
                    w_state = ST_IDLE;
                    w_count = 4'd0;
                end
`ifdef LCP_UNDO_EN
                w_snap_valid = 1'b0;
`endif
            end else if (w_is_sel && w_edit_mode && w_in_range) begin
                if (r_count == 4'(MAX_MOVES)) begin
                    w_fail = 1'b1;
                end else begin
                    w_count = r_count + 4'd1;
`ifdef LCP_UNDO_EN
                    w_snap_valid = 1'b1;
                    w_snap_op    = (r_state == ST_OP);
                    w_snap_idx   = w_idx;
`endif
                    if (r_state == ST_OP) begin
                        for (int k = 0; k < N_STAGES; k++) begin
                            if (w_idx == 4'(k)) begin
                                w_ops[k] = r_ops[k] + 2'd1;
`ifdef LCP_UNDO_EN
                                w_snap_val = {6'd0, r_ops[k]};
`endif
                            end
                        end
                    end else begin
                        for (int k = 0; k <= N_STAGES; k++) begin
                            if (w_idx == 4'(k)) begin
                                w_nums[k] = (r_state == ST_INV) ? ~r_nums[k] : rotl1(r_nums[k]);
`ifdef LCP_UNDO_EN
                                w_snap_val = 8'(r_nums[k]);
`endif
                            end
                        end
                    end
                end
            end
`ifdef LCP_UNDO_EN
            else if ((key_value == c_key_hash) && r_snap_valid) begin
                w_count      = r_count - 4'd1;
                w_snap_valid = 1'b0;
                if (r_snap_op) begin
                    for (int k = 0; k < N_STAGES; k++)
                        if (r_snap_idx == 4'(k)) w_ops[k] = r_snap_val[1:0];
                end else begin
                    for (int k = 0; k <= N_STAGES; k++)
                        if (r_snap_idx == 4'(k)) w_nums[k] = r_snap_val[WIDTH-1:0];
                end
            end
`endif
        end

        w_led = {4'(MAX_MOVES) - w_count, 4'b0000};
        case (w_state)
            ST_INV:  w_led[2:0] = 3'b001;
            ST_OP:   w_led[2:0] = 3'b010;
            ST_ROT:  w_led[2:0] = 3'b100;
            default: w_led[2:0] = 3'b000;
        endcase
    end

    // led_out is registered so it reads zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nums    <= w_init;
            r_ops     <= '0;
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_clear   <= 1'b0;
            r_fail    <= 1'b0;
            r_correct <= 1'b0;
            r_led     <= 8'd0;
`ifdef LCP_UNDO_EN
            r_snap_valid <= 1'b0;
            r_snap_op    <= 1'b0;
            r_snap_idx   <= 4'd0;
            r_snap_val   <= 8'd0;
`endif
        end else begin
            r_nums    <= w_nums;
            r_ops     <= w_ops;
            r_state   <= w_state;
            r_count   <= w_count;
            r_clear   <= w_clear;
            r_fail    <= w_fail;
            r_correct <= w_correct;
            r_led     <= w_led;
`ifdef LCP_UNDO_EN
            r_snap_valid <= w_snap_valid;
            r_snap_op    <= w_snap_op;
            r_snap_idx   <= w_snap_idx;
            r_snap_val   <= w_snap_val;
`endif
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_seg
        if (gi < WIDTH) begin : g_bit
            assign seg_data[4*gi +: 4] = enable ? {3'b000, w_result[gi]} : 4'h0;
        end else begin : g_pad
            assign seg_data[4*gi +: 4] = 4'h0;
        end
    end

    assign led_out = r_led;
    assign clear   = r_clear & enable;
    assign fail    = r_fail & enable;
    assign correct = r_correct & enable;

endmodule
`default_nettype wire

// File: tb/tb_logic_chain_puzzle.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_chain_puzzle
// Description : Scoreboard bench for logic_chain_puzzle with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_logic_chain_puzzle;

    localparam int         WIDTH     = 8;
    localparam int         N_STAGES  = 8;
    localparam int         MAX_MOVES = 12;
    localparam int         TARGET    = 255;
    localparam int         MASK      = (1 << WIDTH) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b1;
    logic [N_STAGES-1:0] dip_sw = '0;
    logic                key_valid = 1'b0;
    logic [3:0]          key_value = 4'd0;
    logic [31:0]         seg_data;
    logic [7:0]          led_out;
    logic                clear, fail, correct;

    always #5 clk = ~clk;

    logic_chain_puzzle #(.WIDTH(WIDTH), .N_STAGES(N_STAGES), .MAX_MOVES(MAX_MOVES)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dip_sw(dip_sw),
        .key_valid(key_valid), .key_value(key_value), .seg_data(seg_data),
        .led_out(led_out), .clear(clear), .fail(fail), .correct(correct)
    );

    typedef struct {
        logic [2:0]  pulses;   // {clear, fail, correct}
        logic [31:0] seg;
        logic [7:0]  led;
        int          key;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 idle, 1 invert, 2 operator, 3 rotate, 4 solved
    int m_nums[N_STAGES+1];
    int m_ops[N_STAGES];
    int m_mode, m_cnt;
    bit m_uv;
    int m_ukind, m_uidx, m_uval;

    function automatic void m_reset();
        for (int k = 0; k <= N_STAGES; k++) m_nums[k] = ((18 + 34 * k) % 256) & MASK;
        for (int k = 0; k < N_STAGES; k++) m_ops[k] = 0;
        m_mode = 0; m_cnt = 0; m_uv = 0;
    endfunction

    function automatic int m_result();
        int r = m_nums[0];
        for (int i = 0; i < N_STAGES; i++) begin
            if (dip_sw[i]) begin
                case (m_ops[i])
                    0: r = r & m_nums[i+1];
                    1: r = r | m_nums[i+1];
                    2: r = r ^ m_nums[i+1];
                    default: r = (~(r ^ m_nums[i+1])) & MASK;
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] m_seg(input bit en);
        logic [31:0] s = 32'd0;
        int r = m_result();
        if (!en) return 32'd0;
        for (int i = 0; i < WIDTH; i++) if (((r >> i) & 1) == 1) s[4*i] = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] m_led();
        int modebits = (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : (m_mode == 3) ? 4 : 0;
        return 8'(((MAX_MOVES - m_cnt) * 16) + modebits);
    endfunction

    function automatic exp_t m_key(input int k, input bit en);
        exp_t e;
        e.pulses = 3'b000;
        e.key    = k;
        if (en && m_mode != 4) begin
            if (k == 10) begin
                m_mode = (m_mode == 3) ? 0 : m_mode + 1;
            end else if (k == 0) begin
                if (m_result() == TARGET) begin
                    e.pulses = 3'b101; m_mode = 4;
                end else begin
                    e.pulses = 3'b010; m_mode = 0; m_cnt = 0;
                end
                m_uv = 0;
            end else if (k >= 1 && k <= 9 && m_mode >= 1 && m_mode <= 3 &&
                         k <= ((m_mode == 2) ? N_STAGES : N_STAGES + 1)) begin
                if (m_cnt == MAX_MOVES) begin
                    e.pulses = 3'b010;
                end else begin
                    m_cnt++; m_uv = 1; m_uidx = k - 1; m_ukind = m_mode;
                    if (m_mode == 2) begin
                        m_uval = m_ops[k-1];
                        m_ops[k-1] = (m_ops[k-1] + 1) % 4;
                    end else begin
                        m_uval = m_nums[k-1];
                        if (m_mode == 1) m_nums[k-1] = MASK - m_nums[k-1];
                        else m_nums[k-1] = ((m_nums[k-1] * 2) % (1 << WIDTH)) + (m_nums[k-1] / (1 << (WIDTH - 1)));
                    end
                end
            end else if (k == 11) begin
`ifdef LCP_UNDO_EN
                if (m_uv) begin
                    if (m_ukind == 2) m_ops[m_uidx] = m_uval;
                    else m_nums[m_uidx] = m_uval;
                    m_cnt--; m_uv = 0;
                end
`endif
            end
        end
        e.seg = m_seg(en);
        e.led = m_led();
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic press(input int k, input bit en);
        exp_t e;
        @(posedge clk); #1;
        enable    = en;
        key_value = 4'(k);
        key_valid = 1'b1;
        e = m_key(k, en);
        q.push_back(e);
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(negedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic do_reset(input logic [N_STAGES-1:0] d);
        @(negedge clk);
        dip_sw = d;
        rst_n  = 1'b0;
        m_reset();
        #1;
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_pulses", 32'({clear, fail, correct}), 32'h0);
        chk("reset_seg", seg_data, m_seg(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_led", 32'(led_out), 32'(m_led()));
    endtask

    // Monitor: every sampled key strobe yields one response on the next cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (key_valid && rst_n) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_underflow: got response with empty queue, expected none");
                end else begin
                    e = q.pop_front();
                    chk($sformatf("pulses_key%0d", e.key), 32'({clear, fail, correct}), 32'(e.pulses));
                    chk($sformatf("seg_key%0d", e.key), seg_data, e.seg);
                    chk($sformatf("led_key%0d", e.key), 32'(led_out), 32'(e.led));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, key;
        bit en;
        m_reset();
        repeat (2) @(negedge clk);

        // Solve with the default operands: invert 1,2 then set two ORs
        do_reset(8'h03);
        press(10, 1); press(1, 1); press(2, 1);
        press(10, 1); press(1, 1); press(2, 1);
        press(0, 1);
        chk("solve_led", 32'(led_out), 32'h80);
        chk("solve_seg", seg_data, 32'h1111_1111);
        // Solved: further keys ignored, then reset restores defaults
        press(10, 1); press(1, 1); press(0, 1);
        chk("done_led_hold", 32'(led_out), 32'h80);
        do_reset(8'h03);

        // Wrong submit with empty chain
        do_reset(8'h00);
        press(0, 1);
        chk("fail_seg", seg_data, 32'h0001_0010);

        // Rotation changes the AND result from 0x10 to 0x00
        do_reset(8'h01);
        chk("rot_before", seg_data, 32'h0001_0000);
        press(10, 1); press(10, 1); press(10, 1); press(2, 1);
        chk("rot_after", seg_data, 32'h0000_0000);

        // Move budget: exhaust then one rejected edit, then out-of-range keys
        do_reset(8'hFF);
        press(10, 1);
        for (int i = 0; i < MAX_MOVES + 1; i++) press(1, 1);
        chk("budget_led", 32'(led_out), 32'h01);
        press(10, 1); press(9, 1); press(13, 1);
        press(0, 1);

        // Undo (no effect unless built in)
        do_reset(8'h00);
        press(10, 1); press(1, 1); press(11, 1); press(11, 1);
        press(10, 1); press(3, 1); press(0, 1); press(11, 1);

        // Disabled keys
        do_reset(8'h0F);
        press(10, 0); press(10, 1); press(1, 0); press(1, 1);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            do_reset(N_STAGES'($urandom));
            for (int n = 0; n < 150; n++) begin
                sel = $urandom_range(0, 99);
                if (sel < 25)      key = 10;
                else if (sel < 80) key = $urandom_range(1, 9);
                else if (sel < 85) key = 0;
                else if (sel < 92) key = 11;
                else               key = $urandom_range(12, 15);
                en = ($urandom_range(0, 9) != 0);
                press(key, en);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
